// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between a load/store unit and dmem_responder
interface dmem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [3:0]            req_wmask;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wmask, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wmask, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory with fixed response latency LAT
// Optional lane-overflow fault checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LAT        = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic [1:0]            boff;
    logic [DEPTH_LOG2-1:0] widx;
    logic [3:0]            lane_mask;
    logic [DATA_WIDTH-1:0] lane_data;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  range_err;
    logic                  misalign_err;
    logic                  fault;

    assign boff      = bus.req_addr[1:0];
    assign widx      = bus.req_addr[DEPTH_LOG2+1:2];
    assign lane_data = bus.req_wdata << {boff, 3'b000};
    assign rd_word   = mem[widx] >> {boff, 3'b000};
    assign range_err = (bus.req_addr >> (DEPTH_LOG2 + 2)) != 32'd0;

`ifdef DMEM_MISALIGN_CHECK_EN
    // Lanes pushed past byte 3 would spill into the next word: treat as a fault.
    logic [6:0] mask_wide;
    assign mask_wide    = {3'b000, bus.req_wmask} << boff;
    assign lane_mask    = mask_wide[3:0];
    assign misalign_err = |mask_wide[6:4];
`else
    assign lane_mask    = bus.req_wmask << boff;
    assign misalign_err = 1'b0;
`endif

    assign fault  = range_err | misalign_err;
    assign accept = bus.req_valid && bus.req_ready && !rst;

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    err_d   = fault;
                    rdata_d = (bus.req_we || fault) ? '0 : rd_word;
                    if (LAT == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Stores commit on the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) begin
                    mem[widx][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder against a byte-level memory model
module tb_dmem_responder;
    localparam int LAT = 2;
    localparam int MEM_BYTES = 4096;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    dmem_responder_if #(.DATA_WIDTH(32)) bus ();

    dmem_responder #(
        .DATA_WIDTH(32),
        .DEPTH_LOG2(10),
        .LAT       (LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ref_mem [MEM_BYTES];
    bit          bp_en;
    bit          hold_low;
    bit          in_resp;
    bit          expect_idle;
    logic [31:0] cur_rdata;
    logic        cur_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bus.resp_ready = hold_low ? 1'b0 : (bp_en ? ($urandom_range(0, 2) != 0) : 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Byte-addressed reference: the access touches bytes addr..addr+3 that stay inside its word.
    task automatic model(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, output logic [31:0] rdata, output logic err);
        int          off;
        logic [11:0] idx;
        off   = int'(addr[1:0]);
        err   = (addr >= 32'(MEM_BYTES));
`ifdef DMEM_MISALIGN_CHECK_EN
        for (int i = 0; i < 4; i++)
            if (mask[i] && (off + i > 3)) err = 1'b1;
`endif
        rdata = 32'd0;
        if (!err) begin
            for (int i = 0; i < 4; i++) begin
                if (off + i <= 3) begin
                    idx = 12'(addr + 32'(i));
                    if (we) begin
                        if (mask[i]) ref_mem[idx] = data[8*i +: 8];
                    end else begin
                        rdata[8*i +: 8] = ref_mem[idx];
                    end
                end
            end
        end
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data);
        exp_t e;
        bit   done;
        done          = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wmask = mask;
        bus.req_wdata = data;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.req_ready && !rst) begin
                model(we, addr, mask, data, e.rdata, e.err);
                e.acc = cyc + 1;
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        check("txn_accepted", 32'(done), 32'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            in_resp     = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (expect_idle) begin
                check("idle_after_handshake", 32'(bus.req_ready), 32'd1);
                expect_idle = 1'b0;
            end
            if (bus.resp_valid) begin
                check("req_ready_low_in_resp", 32'(bus.req_ready), 32'd0);
                if (!in_resp) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_response: got rdata %h err %b expected none",
                                 bus.resp_rdata, bus.resp_err);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_rdata", bus.resp_rdata, e.rdata);
                        check("resp_err", 32'(bus.resp_err), 32'(e.err));
                        check("latency", 32'(cyc - e.acc + 1), 32'(LAT));
                    end
                    in_resp   = 1'b1;
                    cur_rdata = bus.resp_rdata;
                    cur_err   = bus.resp_err;
                end else begin
                    check("rdata_stable", bus.resp_rdata, cur_rdata);
                    check("err_stable", 32'(bus.resp_err), 32'(cur_err));
                end
                if (bus.resp_ready) begin
                    in_resp     = 1'b0;
                    expect_idle = 1'b1;
                end
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 100 && (exp_q.size() != 0 || in_resp); k++) @(posedge clk);
        #1;
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  m;
        logic        w;
        int          sel;
        bit          seen;

        checks        = 0;
        errors        = 0;
        cyc           = 0;
        bp_en         = 1'b0;
        hold_low      = 1'b0;
        in_resp       = 1'b0;
        expect_idle   = 1'b0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wmask = 4'd0;
        bus.req_wdata = 32'd0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset_resp_rdata", bus.resp_rdata, 32'd0);
        check("reset_resp_err", 32'(bus.resp_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int wi = 0; wi < 17; wi++) begin
            a = (wi == 16) ? 32'hFFC : 32'(wi * 4);
            do_txn(1'b1, a, 4'hF, $urandom);
        end

        do_txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        do_txn(1'b0, 32'h10, 4'hF, 32'h0);
        do_txn(1'b1, 32'h13, 4'h1, 32'h000000AB);
        do_txn(1'b0, 32'h10, 4'hF, 32'h0);
        do_txn(1'b0, 32'h13, 4'h1, 32'h0);
        drain();
        check("ref_word_0x10", {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]}, 32'hABADBEEF);

        hold_low = 1'b1;
        do_txn(1'b0, 32'h10, 4'hF, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.resp_valid;
        end
        check("bp_resp_seen", 32'(seen), 32'd1);
        repeat (5) @(posedge clk);
        hold_low = 1'b0;
        drain();

        do_txn(1'b1, 32'h03, 4'h3, 32'h0000CDEF);
        do_txn(1'b0, 32'h00, 4'hF, 32'h0);
        do_txn(1'b1, 32'h1000, 4'hF, 32'h11223344);
        do_txn(1'b0, 32'h1000, 4'hF, 32'h0);
        do_txn(1'b0, 32'h0, 4'hF, 32'h0);
        do_txn(1'b0, 32'hFFC, 4'hF, 32'h0);
        do_txn(1'b0, 32'hFFF, 4'h1, 32'h0);
        drain();

        do_txn(1'b1, 32'h20, 4'hF, 32'hCAFEF00D);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst_in_wait_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_wait_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        do_txn(1'b0, 32'h20, 4'hF, 32'h0);
        drain();

        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h14;
        bus.req_wmask = 4'hF;
        bus.req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        do_txn(1'b0, 32'h14, 4'hF, 32'h0);
        drain();

        bp_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 19);
            if (sel < 16)      a = 32'(sel * 4) | 32'($urandom_range(0, 3));
            else if (sel < 18) a = 32'hFFC | 32'($urandom_range(0, 3));
            else               a = 32'h1000 + 32'($urandom_range(0, 65535));
            case ($urandom_range(0, 3))
                0:       m = 4'h1;
                1:       m = 4'h3;
                2:       m = 4'hF;
                default: m = 4'($urandom_range(0, 15));
            endcase
            w = 1'($urandom_range(0, 1));
            do_txn(w, a, m, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        bp_en = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
